// File: rtl/cache_ctrl.sv
// ---------------------------------------------------------------------------
// cache_ctrl
//
// Purpose:
//    Cache management FSM between the CPU memory stage and a 2-way
//    set-associative cache storage array. A lookup takes two cycles
//    (present address, then check the registered hit). On a miss the CPU is
//    stalled. A dirty victim line is written back word by word. The line is
//    then refilled from main memory, and the held request is replayed so it
//    hits.
//
// Ports:
//    clk, rst            clock, asynchronous active-high reset
//    addr_rw             CPU byte address (held while stall=1)
//    en_r / en_w         CPU load / store request (store wins)
//    u_b_h_w             RV32I width/sign code of the access
//    data_w / data_r     CPU store data / CPU load data
//    stall               CPU must hold its request
//    cache_addr          address presented to the cache array
//    cache_load          lookup strobe for a load
//    cache_store         full-word refill write strobe
//    cache_edit          CPU store (merge) strobe
//    cache_invalid       invalidate strobe (unused, tied low)
//    cache_u_b_h_w       width code to the cache
//    cache_din           write data to the cache
//    cache_hit           registered cache status for the last address
//    cache_valid         registered valid bit of the selected/victim line
//    cache_dirty         registered dirty bit of the selected/victim line
//    cache_tag           registered tag of the victim line
//    cache_dout          registered cache read data
//    mem_cs_o, mem_we_o  main memory request / write enable
//    mem_addr_o          word-aligned memory address
//    mem_data_o          memory write data
//    mem_data_i          memory read data (valid with mem_ack_i)
//    mem_ack_i           single-cycle completion of a memory transfer
// ---------------------------------------------------------------------------
module cache_ctrl #(
   parameter int ADDR_BITS           = 32,
   parameter int TAG_BITS            = 23,
   parameter int SET_INDEX_WIDTH     = 5,
   parameter int ELEMENT_WORDS_WIDTH = 2,
   parameter int WORD_BYTES_WIDTH    = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ADDR_BITS-1:0]       addr_rw,
   input  logic                       en_r,
   input  logic                       en_w,
   input  logic [2:0]                 u_b_h_w,
   input  logic [31:0]                data_w,
   output logic [31:0]                data_r,
   output logic                       stall,
   output logic [ADDR_BITS-1:0]       cache_addr,
   output logic                       cache_load,
   output logic                       cache_store,
   output logic                       cache_edit,
   output logic                       cache_invalid,
   output logic [2:0]                 cache_u_b_h_w,
   output logic [31:0]                cache_din,
   input  logic                       cache_hit,
   input  logic                       cache_valid,
   input  logic                       cache_dirty,
   input  logic [TAG_BITS-1:0]        cache_tag,
   input  logic [31:0]                cache_dout,
   output logic                       mem_cs_o,
   output logic                       mem_we_o,
   output logic [ADDR_BITS-1:0]       mem_addr_o,
   output logic [31:0]                mem_data_o,
   input  logic [31:0]                mem_data_i,
   input  logic                       mem_ack_i
);

   localparam int OFFSET_BITS = ELEMENT_WORDS_WIDTH + WORD_BYTES_WIDTH;
   localparam logic [ELEMENT_WORDS_WIDTH-1:0] CNT_ONE  = 1;
   localparam logic [ELEMENT_WORDS_WIDTH-1:0] CNT_LAST = '1;
   localparam logic [2:0] WIDTH_WORD = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_BK_RD,
      S_BK_WR,
      S_FILL
   } state_t;

   state_t                         r_state;
   state_t                         w_state_next;
   logic [ELEMENT_WORDS_WIDTH-1:0] r_word_cnt;
   logic [ELEMENT_WORDS_WIDTH-1:0] w_word_cnt_next;
   logic [TAG_BITS-1:0]            r_victim_tag;
   logic [TAG_BITS-1:0]            w_victim_tag_next;
   logic [31:0]                    r_data_r;
   logic [31:0]                    w_data_r_next;

   logic                           w_req;
   logic [TAG_BITS-1:0]            w_addr_tag;
   logic [SET_INDEX_WIDTH-1:0]     w_addr_index;
   logic [ADDR_BITS-1:0]           w_line_addr;
   logic [ADDR_BITS-1:0]           w_victim_addr;
   logic                           w_last_word;

   assign w_req        = en_r | en_w;
   assign w_addr_tag   = addr_rw[ADDR_BITS-1 -: TAG_BITS];
   assign w_addr_index = addr_rw[OFFSET_BITS +: SET_INDEX_WIDTH];
   assign w_last_word  = (r_word_cnt == CNT_LAST);

   // Word currently being moved, in the requested line and in the victim line
   assign w_line_addr   = {w_addr_tag, w_addr_index, r_word_cnt, {WORD_BYTES_WIDTH{1'b0}}};
   assign w_victim_addr = {r_victim_tag, w_addr_index, r_word_cnt, {WORD_BYTES_WIDTH{1'b0}}};

   // The only cycle a request is not stalled is the check cycle that hits
   assign stall         = w_req & ~((r_state == S_CHECK) & cache_hit);
   assign cache_invalid = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_word_cnt   <= '0;
         r_victim_tag <= '0;
         r_data_r     <= '0;
      end else begin
         r_state      <= w_state_next;
         r_word_cnt   <= w_word_cnt_next;
         r_victim_tag <= w_victim_tag_next;
         r_data_r     <= w_data_r_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_word_cnt_next   = r_word_cnt;
      w_victim_tag_next = r_victim_tag;
      w_data_r_next     = r_data_r;
      data_r            = r_data_r;
      cache_addr        = addr_rw;
      cache_load        = 1'b0;
      cache_store       = 1'b0;
      cache_edit        = 1'b0;
      cache_u_b_h_w     = WIDTH_WORD;
      cache_din         = data_w;
      mem_cs_o          = 1'b0;
      mem_we_o          = 1'b0;
      mem_addr_o        = w_line_addr;
      mem_data_o        = cache_dout;

      case (r_state)
         S_IDLE: begin
            cache_u_b_h_w = u_b_h_w;
            // Strobes are masked while reset is held so the array sees no
            // access even if the CPU keeps a request up through reset.
            cache_edit    = en_w & ~rst;
            cache_load    = en_r & ~en_w & ~rst;
            if (w_req) begin
               w_state_next = S_CHECK;
            end
         end

         S_CHECK: begin
            cache_u_b_h_w = u_b_h_w;
            if (cache_hit) begin
               data_r        = cache_dout;
               w_data_r_next = cache_dout;
               w_state_next  = S_IDLE;
            end else if (cache_valid & cache_dirty) begin
               w_victim_tag_next = cache_tag;
               w_word_cnt_next   = '0;
               w_state_next      = S_BK_RD;
            end else begin
               w_word_cnt_next = '0;
               w_state_next    = S_FILL;
            end
         end

         S_BK_RD: begin
            // The requested tag misses, so the array returns the victim
            // way's word at this offset on cache_dout next cycle.
            cache_addr   = w_line_addr;
            w_state_next = S_BK_WR;
         end

         S_BK_WR: begin
            cache_addr = w_line_addr;
            mem_cs_o   = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = w_victim_addr;
            if (mem_ack_i) begin
               if (w_last_word) begin
                  w_word_cnt_next = '0;
                  w_state_next    = S_FILL;
               end else begin
                  w_word_cnt_next = r_word_cnt + CNT_ONE;
                  w_state_next    = S_BK_RD;
               end
            end
         end

         S_FILL: begin
            mem_cs_o = 1'b1;
            if (mem_ack_i) begin
               cache_store = 1'b1;
               cache_addr  = w_line_addr;
               cache_din   = mem_data_i;
               if (w_last_word) begin
                  // Request is still held: IDLE replays the lookup
                  w_state_next = S_IDLE;
               end else begin
                  w_word_cnt_next = r_word_cnt + CNT_ONE;
               end
            end
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

endmodule
